sc_stream_decoder: RTL and testbench

Stochastic-to-binary converter. It is the decoding end of the bitstream datapath: adders and multipliers produce unipolar stochastic bitstreams, and this block turns one of them back into a binary count. It counts the ones in x over a window of 2^WIDTH qualified bits, then presents the count on result with a one-cycle done pulse. It supports single-shot (start-triggered) and back-to-back continuous windows.

---
 rtl/sc_pkg.sv | 16 +
 rtl/sc_window_counter.sv | 36 +++
 rtl/sc_stream_decoder.sv | 110 +++++++++++
 tb/tb_sc_stream_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for bitstream-domain blocks.
// Contents:
//   sc_state_t    - two-state window controller encoding (SC_IDLE, SC_ACCUM)
//   sc_window_len - number of bits in a window of 2^width bits
package sc_pkg;

  typedef enum logic {
    SC_IDLE  = 1'b0,
    SC_ACCUM = 1'b1
  } sc_state_t;

  function automatic int unsigned sc_window_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Valid-bit position counter for one stochastic window.
// Ports:
//   clk, rst  - clock, async active-high reset
//   zero      - synchronous clear to 0 (wins over en)
//   en        - count one accepted bit
//   count     - bits accepted so far in the window (wraps at 2^WIDTH)
//   terminal  - the bit being accepted now is the last bit of the window
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zero,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam int unsigned WIN_LEN = sc_window_len(WIDTH);
  localparam logic [WIDTH-1:0] LAST_POS = WIDTH'(WIN_LEN - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (zero) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = en && (count == LAST_POS);

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones of x over 2^WIDTH qualified bits
// and publishes the count on result with a one-cycle done pulse.
// Ports:
//   clk, rst  - clock, async active-high reset
//   start     - begin a window (only honoured in IDLE)
//   clear     - synchronous abort back to IDLE, result kept
//   in_valid  - qualifies x
//   x         - stochastic bitstream bit
//   busy      - window accumulating
//   done      - one-cycle pulse, result updated in the same cycle
//   result    - ones count of the last completed window (0..2^WIDTH)
//
// state    | meaning
// SC_IDLE  | waiting for start (or the post-reset launch when AUTO_RESTART)
// SC_ACCUM | accumulating valid bits of the current window
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           clear,
  input  logic           in_valid,
  input  logic           x,
  output logic           busy,
  output logic           done,
  output logic [WIDTH:0] result
);

  sc_state_t      state_q, state_d;
  logic [WIDTH:0] ones_q, ones_d;
  logic [WIDTH:0] result_d;
  logic           done_d;
  logic           cnt_zero, cnt_en, terminal;
  logic [WIDTH-1:0] bit_cnt;
  // One-shot flag that lets an auto-restarting decoder leave reset straight
  // into a window; a later clear still needs start to resume.
  logic           launch_q;

  sc_window_counter #(.WIDTH(WIDTH)) u_window (
    .clk      (clk),
    .rst      (rst),
    .zero     (cnt_zero),
    .en       (cnt_en),
    .count    (bit_cnt),
    .terminal (terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SC_IDLE;
      ones_q   <= '0;
      result   <= '0;
      done     <= 1'b0;
      launch_q <= AUTO_RESTART;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      result   <= result_d;
      done     <= done_d;
      launch_q <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    result_d = result;
    done_d   = 1'b0;
    cnt_zero = 1'b0;
    cnt_en   = 1'b0;
    busy     = (state_q == SC_ACCUM);

    if (clear) begin
      state_d  = SC_IDLE;
      ones_d   = '0;
      cnt_zero = 1'b1;
    end else begin
      case (state_q)
        SC_IDLE: begin
          if (start || launch_q) begin
            state_d  = SC_ACCUM;
            ones_d   = '0;
            cnt_zero = 1'b1;
          end
        end
        SC_ACCUM: begin
          if (in_valid) begin
            cnt_en = 1'b1;
            ones_d = ones_q + (WIDTH+1)'(x);
          end
          if (terminal) begin
            // The closing bit is folded in directly; the accumulator restarts
            // at zero so a back-to-back window can take a bit next cycle.
            result_d = ones_q + (WIDTH+1)'(x);
            done_d   = 1'b1;
            ones_d   = '0;
            cnt_zero = 1'b1;
            if (!AUTO_RESTART) state_d = SC_IDLE;
          end
        end
        default: state_d = SC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
module tb_sc_stream_decoder;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, start0, clear0, in_valid0, x0, busy0, done0;
  logic [W:0] result0;
  logic rst1, start1, clear1, in_valid1, x1, busy1, done1;
  logic [W:0] result1;

  int errors = 0;
  int checks = 0;

  sc_stream_decoder #(.WIDTH(W), .AUTO_RESTART(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .clear(clear0), .in_valid(in_valid0),
    .x(x0), .busy(busy0), .done(done0), .result(result0)
  );

  sc_stream_decoder #(.WIDTH(W), .AUTO_RESTART(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .clear(clear1), .in_valid(in_valid1),
    .x(x1), .busy(busy1), .done(done1), .result(result1)
  );

  typedef struct {
    logic [31:0] valid;
    logic [31:0] xs;
    int          ncyc;
    int          exp_result;
    string       name;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are driven at a falling edge; the following falling edge is where
  // outputs are sampled.
  task automatic step0(input logic s, input logic c, input logic v, input logic b);
    start0 = s; clear0 = c; in_valid0 = v; x0 = b;
    @(negedge clk);
  endtask

  task automatic step1(input logic s, input logic c, input logic v, input logic b);
    start1 = s; clear1 = c; in_valid1 = v; x1 = b;
    @(negedge clk);
  endtask

  // Start cycle carries x=1/in_valid=1, which must not be counted.
  task automatic run_vec(input vec_t t);
    int nvalid;
    int last;
    nvalid = 0;
    last   = -1;
    for (int i = 0; i < t.ncyc; i++) begin
      if (t.valid[i]) begin
        nvalid++;
        if (nvalid == N && last < 0) last = i;
      end
    end
    step0(1'b1, 1'b0, 1'b1, 1'b1);
    chk({t.name, " busy after start"}, 32'(busy0), 32'd1);
    for (int i = 0; i < t.ncyc; i++) begin
      step0(1'b0, 1'b0, t.valid[i], t.xs[i]);
      chk({t.name, " done"}, 32'(done0), 32'(i == last));
      if (i == last) begin
        chk({t.name, " result"}, 32'(result0), 32'(t.exp_result));
        chk({t.name, " busy in done cycle"}, 32'(busy0), 32'd0);
      end
    end
  endtask

  // Reference: a window is simply the next N accepted bits; its result is how
  // many of them were ones.
  task automatic rand_windows(input int nwin);
    int ones;
    int nv;
    int cyc;
    logic v;
    logic b;
    for (int w = 0; w < nwin; w++) begin
      ones = 0;
      nv   = 0;
      cyc  = 0;
      step0(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      while (nv < N) begin
        v = ($urandom_range(0, 3) != 0) || (cyc > 100);
        b = 1'($urandom_range(0, 1));
        step0(1'b0, 1'b0, v, b);
        cyc++;
        if (v) begin
          nv++;
          ones += int'(b);
        end
        chk("rand done", 32'(done0), 32'(nv == N));
        if (nv == N) chk("rand result", 32'(result0), 32'(ones));
      end
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000FFFF, 32'h0000FFFF, 16, 16, "all_ones"};
    vecs[1] = '{32'h0000FFFF, 32'h00005555, 16, 8,  "alternating"};
    vecs[2] = '{32'h55555555, 32'hAAAAABFF, 32, 5,  "gapped"};
    vecs[3] = '{32'h0000FFFF, 32'h00000000, 16, 0,  "all_zeros"};
    vecs[4] = '{32'hFFFF0000, 32'h8001FFFF, 32, 2,  "late_valid"};

    rst0 = 1'b0; rst1 = 1'b0;
    start0 = 1'b0; clear0 = 1'b0; in_valid0 = 1'b0; x0 = 1'b0;
    start1 = 1'b0; clear1 = 1'b0; in_valid1 = 1'b0; x1 = 1'b0;
    #1;
    rst0 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset done", 32'(done0), 32'd0);
    chk("reset result", 32'(result0), 32'd0);
    chk("reset busy auto", 32'(busy1), 32'd0);
    rst0 = 1'b0;
    step0(1'b0, 1'b0, 1'b1, 1'b1);
    chk("idle without start", 32'(busy0), 32'd0);

    foreach (vecs[k]) run_vec(vecs[k]);

    rand_windows(6);

    // Back-to-back windows: leaves reset straight into ACCUM.
    rst1 = 1'b0;
    @(negedge clk);
    chk("auto launch busy", 32'(busy1), 32'd1);
    begin
      int ones;
      int nv;
      logic b;
      ones = 0;
      nv   = 0;
      for (int k = 0; k < 2 * N; k++) begin
        b = (k < 3) || (k >= N && k < N + 12);
        step1(1'b0, 1'b0, 1'b1, b);
        nv++;
        ones += int'(b);
        chk("auto busy", 32'(busy1), 32'd1);
        chk("auto done", 32'(done1), 32'(nv == N));
        if (nv == N) begin
          chk("auto result", 32'(result1), 32'(ones));
          ones = 0;
          nv   = 0;
        end
      end
    end
    chk("auto last result", 32'(result1), 32'd12);
    step1(1'b0, 1'b1, 1'b1, 1'b1);
    chk("auto clear busy", 32'(busy1), 32'd0);
    chk("auto clear done", 32'(done1), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step1(1'b0, 1'b0, 1'b1, 1'b1);
      chk("auto stays idle", 32'(busy1), 32'd0);
    end
    step1(1'b1, 1'b0, 1'b0, 1'b0);
    chk("auto restart by start", 32'(busy1), 32'd1);

    // clear together with the closing bit wins over the window end.
    run_vec(vecs[1]);
    step0(1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < N - 1; k++) step0(1'b0, 1'b0, 1'b1, 1'b1);
    chk("pre-clear busy", 32'(busy0), 32'd1);
    step0(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clear done", 32'(done0), 32'd0);
    chk("clear busy", 32'(busy0), 32'd0);
    chk("clear result kept", 32'(result0), 32'd8);
    for (int k = 0; k < 2; k++) begin
      step0(1'b0, 1'b0, 1'b1, 1'b1);
      chk("after clear done", 32'(done0), 32'd0);
      chk("after clear busy", 32'(busy0), 32'd0);
    end

    // Asynchronous reset in the middle of a window.
    step0(1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step0(1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    rst0 = 1'b1;
    #1;
    chk("async rst busy", 32'(busy0), 32'd0);
    chk("async rst done", 32'(done0), 32'd0);
    chk("async rst result", 32'(result0), 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    step0(1'b0, 1'b0, 1'b1, 1'b1);
    chk("post rst idle", 32'(busy0), 32'd0);
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
